// File: rtl/csi2_raw_depacker.sv
// CSI-2 long-packet payload depacker: RAW8/RAW10/RAW12 bytes in, four LSB-aligned pixels per beat out.
// Group size is latched per packet; leftover bytes at packet end are flushed and flagged.
module csi2_raw_depacker #(
    parameter int IN_BYTES = 4,
    parameter int PX_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              raw_mode_i,
    input  logic [8*IN_BYTES-1:0]   s_tdata_i,
    input  logic [IN_BYTES-1:0]     s_tstrb_i,
    input  logic                    s_tlast_i,
    input  logic                    s_tvalid_i,
    output logic                    s_tready_o,
    output logic [4*PX_WIDTH-1:0]   m_tdata_o,
    output logic                    m_tuser_o,
    output logic                    m_tlast_o,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic                    len_err_o
);

    localparam int BUF = 12 + IN_BYTES;
    localparam int CW  = $clog2(BUF + 1);
    localparam int BW  = $clog2(8 * BUF);
    localparam logic [CW-1:0] ACCEPT_MAX = CW'(BUF - IN_BYTES);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic [8*BUF-1:0]     buf_q, buf_d;
    logic [CW-1:0]        fill_q, fill_d;
    logic                 endPending_q, endPending_d;
    logic                 tuserArm_q, tuserArm_d;
    logic                 inPacket_q, inPacket_d;
    logic [1:0]           mode_q, mode_d;

    logic [CW-1:0]        grpSize;
    logic [CW-1:0]        wrPos;
    logic [BW-1:0]        bitPos;
    logic                 outValid;
    logic                 accept;
    logic                 pop;
    logic                 flush;
    logic [7:0]           b [6];
    logic [11:0]          pix [4];
    logic [4*PX_WIDTH-1:0] pixBus;

    always_comb begin
        case (mode_q)
            2'd1:    grpSize = CW'(5);
            2'd2:    grpSize = CW'(6);
            default: grpSize = CW'(4);
        endcase
    end

    // A group is only released early when a full second group stands behind it,
    // so the tlast decision is always known when the last group is presented.
    assign outValid   = (fill_q >= grpSize) && ((fill_q >= (grpSize << 1)) || endPending_q);
    assign flush      = endPending_q && (fill_q < grpSize);
    assign s_tready_o = !rst_i && (fill_q <= ACCEPT_MAX) && !endPending_q;
    assign accept     = s_tvalid_i && s_tready_o;
    assign pop        = m_tvalid_o && m_tready_i;

    always_comb begin
        buf_d        = buf_q;
        fill_d       = fill_q;
        endPending_d = endPending_q;
        tuserArm_d   = tuserArm_q;
        inPacket_d   = inPacket_q;
        mode_d       = mode_q;
        wrPos        = fill_q;
        bitPos       = '0;
        if (pop) begin
            buf_d      = buf_q >> {grpSize, 3'b000};
            wrPos      = fill_q - grpSize;
            tuserArm_d = 1'b0;
        end
        if (accept) begin
            for (int k = 0; k < IN_BYTES; k++) begin
                if (s_tstrb_i[k]) begin
                    bitPos = BW'({wrPos, 3'b000});
                    buf_d[bitPos +: 8] = s_tdata_i[8*k +: 8];
                    wrPos = wrPos + ONE;
                end
            end
            if (!inPacket_q) begin
                mode_d = raw_mode_i;
            end
            inPacket_d = !s_tlast_i;
            if (s_tlast_i) begin
                endPending_d = 1'b1;
            end
        end
        fill_d = wrPos;
        if (flush) begin
            fill_d       = '0;
            endPending_d = 1'b0;
            tuserArm_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q        <= '0;
            fill_q       <= '0;
            endPending_q <= 1'b0;
            tuserArm_q   <= 1'b1;
            inPacket_q   <= 1'b0;
            mode_q       <= 2'd0;
        end else begin
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            endPending_q <= endPending_d;
            tuserArm_q   <= tuserArm_d;
            inPacket_q   <= inPacket_d;
            mode_q       <= mode_d;
        end
    end

    for (genvar i = 0; i < 6; i++) begin : g_bytes
        assign b[i] = buf_q[8*i +: 8];
    end

    always_comb begin
        case (mode_q)
            2'd1: begin
                pix[0] = {2'b00, b[0], b[4][1:0]};
                pix[1] = {2'b00, b[1], b[4][3:2]};
                pix[2] = {2'b00, b[2], b[4][5:4]};
                pix[3] = {2'b00, b[3], b[4][7:6]};
            end
            2'd2: begin
                pix[0] = {b[0], b[2][3:0]};
                pix[1] = {b[1], b[2][7:4]};
                pix[2] = {b[3], b[5][3:0]};
                pix[3] = {b[4], b[5][7:4]};
            end
            default: begin
                pix[0] = {4'h0, b[0]};
                pix[1] = {4'h0, b[1]};
                pix[2] = {4'h0, b[2]};
                pix[3] = {4'h0, b[3]};
            end
        endcase
    end

    for (genvar n = 0; n < 4; n++) begin : g_pix
        assign pixBus[n*PX_WIDTH +: PX_WIDTH] = PX_WIDTH'(pix[n]);
    end

    assign m_tvalid_o = !rst_i && outValid;
    assign m_tlast_o  = m_tvalid_o && endPending_q && ((fill_q - grpSize) < grpSize);
    assign m_tuser_o  = m_tvalid_o && tuserArm_q;
    assign m_tdata_o  = rst_i ? '0 : pixBus;
    assign len_err_o  = !rst_i && flush && (fill_q != '0);

endmodule

// File: tb/tb_csi2_raw_depacker.sv
// Self-checking bench for csi2_raw_depacker: randomized packets compared against a
// byte-queue reference model of the RAW8/RAW10/RAW12 unpacking rules.
module tb_csi2_raw_depacker;

    localparam int IN_BYTES = 4;
    localparam int PXW      = 16;
    localparam int BUFMAX   = 12;

    typedef struct packed {
        logic [4*PXW-1:0] data;
        logic             user;
        logic             last;
    } beat_t;

    logic                  clk;
    logic                  rst;
    logic [1:0]            raw_mode;
    logic [8*IN_BYTES-1:0] s_tdata;
    logic [IN_BYTES-1:0]   s_tstrb;
    logic                  s_tlast;
    logic                  s_tvalid;
    logic                  s_tready;
    logic [4*PXW-1:0]      m_tdata;
    logic                  m_tuser;
    logic                  m_tlast;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  len_err;

    beat_t      expQ[$];
    beat_t      obsQ[$];
    logic [7:0] pkt[$];
    int         compared = 0;
    int         mismatched = 0;
    int         errPulses = 0;
    int         expErrPulses = 0;
    int         stallErr = 0;
    int         readyErr = 0;
    bit         randReady = 0;

    csi2_raw_depacker #(.IN_BYTES(IN_BYTES), .PX_WIDTH(PXW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .raw_mode_i (raw_mode),
        .s_tdata_i  (s_tdata),
        .s_tstrb_i  (s_tstrb),
        .s_tlast_i  (s_tlast),
        .s_tvalid_i (s_tvalid),
        .s_tready_o (s_tready),
        .m_tdata_o  (m_tdata),
        .m_tuser_o  (m_tuser),
        .m_tlast_o  (m_tlast),
        .m_tvalid_o (m_tvalid),
        .m_tready_i (m_tready),
        .len_err_o  (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Observer: collects output beats, counts len_err pulses, and tracks per-packet residency
    // and output stability while stalled.
    logic [4*PXW-1:0] heldData;
    logic             heldUser;
    logic             heldLast;
    bit               stalled = 0;
    bit               monInPkt = 0;
    int               resIn = 0;
    int               resOut = 0;
    int               monG = 4;
    always @(negedge clk) begin
        if (rst) begin
            stalled  = 0;
            monInPkt = 0;
            resIn    = 0;
            resOut   = 0;
        end else begin
            if (stalled && (m_tvalid !== 1'b1 || m_tdata !== heldData ||
                            m_tuser !== heldUser || m_tlast !== heldLast))
                stallErr++;
            stalled  = (m_tvalid === 1'b1) && (m_tready === 1'b0);
            heldData = m_tdata;
            heldUser = m_tuser;
            heldLast = m_tlast;
            if (s_tready === 1'b1 && (resIn - resOut) > BUFMAX)
                readyErr++;
            if (len_err === 1'b1)
                errPulses++;
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                obsQ.push_back('{m_tdata, m_tuser, m_tlast});
                resOut += monG;
            end
            if (s_tvalid === 1'b1 && s_tready === 1'b1) begin
                if (!monInPkt) begin
                    resIn  = 0;
                    resOut = 0;
                    monG   = (raw_mode == 2'd1) ? 5 : (raw_mode == 2'd2) ? 6 : 4;
                end
                resIn   += $countones(s_tstrb);
                monInPkt = !s_tlast;
            end
        end
    end

    initial begin
        #50000000;
        $display("[TB] FAIL watchdog: got no completion, want finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: each group of G bytes yields four pixels by the mode's unpacking rule.
    function automatic void modelPacket(input int mode);
        int    g;
        int    ngrp;
        int    base;
        int    p[4];
        beat_t bt;
        g    = (mode == 1) ? 5 : (mode == 2) ? 6 : 4;
        ngrp = pkt.size() / g;
        for (int gi = 0; gi < ngrp; gi++) begin
            base = gi * g;
            if (g == 6) begin
                p[0] = int'(pkt[base])     * 16 + int'(pkt[base+2]) % 16;
                p[1] = int'(pkt[base+1])   * 16 + int'(pkt[base+2]) / 16;
                p[2] = int'(pkt[base+3])   * 16 + int'(pkt[base+5]) % 16;
                p[3] = int'(pkt[base+4])   * 16 + int'(pkt[base+5]) / 16;
            end else begin
                for (int n = 0; n < 4; n++) begin
                    if (g == 5)
                        p[n] = int'(pkt[base+n]) * 4 + (int'(pkt[base+4]) >> (2*n)) % 4;
                    else
                        p[n] = int'(pkt[base+n]);
                end
            end
            bt.data = '0;
            for (int n = 0; n < 4; n++)
                bt.data[n*PXW +: PXW] = 16'(p[n]);
            bt.user = (gi == 0);
            bt.last = (gi == ngrp - 1);
            expQ.push_back(bt);
        end
        if (pkt.size() % g != 0)
            expErrPulses++;
    endfunction

    task automatic startTest();
        expQ.delete();
        obsQ.delete();
        errPulses    = 0;
        expErrPulses = 0;
        stallErr     = 0;
        readyErr     = 0;
    endtask

    task automatic sendPacket(input int mode, input bit withLast, input bit doSwitch,
                              input int newMode, input bit zeroTail);
        int idx = 0;
        int nb;
        int waitCyc;
        bit lastBeat;
        bit firstBeat = 1;
        raw_mode = 2'(mode);
        do begin
            nb = int'($urandom_range(1, IN_BYTES));
            if (nb > pkt.size() - idx)
                nb = pkt.size() - idx;
            lastBeat = (idx + nb == pkt.size()) && (nb == 0 || !zeroTail);
            s_tdata  = 32'($urandom);
            for (int k = 0; k < nb; k++)
                s_tdata[8*k +: 8] = pkt[idx+k];
            s_tstrb  = IN_BYTES'((1 << nb) - 1);
            s_tlast  = withLast && lastBeat;
            s_tvalid = 1'b1;
            waitCyc  = 0;
            @(negedge clk);
            while (s_tready !== 1'b1 && waitCyc < 300) begin
                @(negedge clk);
                waitCyc++;
            end
            if (s_tready !== 1'b1) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL input_handshake: got s_tready=%b after %0d cycles, want 1", s_tready, waitCyc);
                s_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            idx += nb;
            if (doSwitch && firstBeat)
                raw_mode = 2'(newMode);
            firstBeat = 0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end while (!lastBeat);
    endtask

    task automatic waitOutputs();
        int cyc = 0;
        while (obsQ.size() < expQ.size() && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic randomPacket(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++)
            pkt.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if (m_tvalid !== 1'b0 || m_tuser !== 1'b0 || m_tlast !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got valid/user/last=%b%b%b, want 000", m_tvalid, m_tuser, m_tlast);
        end
        compared++;
        if (m_tdata !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_tdata: got %h, want 0", m_tdata);
        end
        compared++;
        if (s_tready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_tready: got %b, want 0", s_tready);
        end
        compared++;
        if (len_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_len_err: got %b, want 0", len_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (s_tready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_release_tready: got %b, want 1", s_tready);
        end
        compared++;
        if (m_tvalid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release_valid: got %b, want 0", m_tvalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_raw10_basic();
        startTest();
        pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h1B, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hE4};
        modelPacket(1);
        sendPacket(1, 1, 0, 0, 0);
        waitOutputs();
        compared++;
        if (obsQ.size() !== 2) begin
            mismatched++;
            $display("[TB] FAIL raw10_count: got %0d beats, want 2", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            compared++;
            if (obsQ[i] !== expQ[i]) begin
                mismatched++;
                $display("[TB] FAIL raw10_beat%0d: got %h, want %h", i, obsQ[i], expQ[i]);
            end
        end
        compared++;
        if (errPulses !== 0) begin
            mismatched++;
            $display("[TB] FAIL raw10_len_err: got %0d pulses, want 0", errPulses);
        end
    endtask

    task automatic test_raw12_basic();
        startTest();
        pkt = '{8'h12, 8'h34, 8'hBA, 8'h56, 8'h78, 8'hDC};
        modelPacket(2);
        sendPacket(2, 1, 0, 0, 0);
        waitOutputs();
        compared++;
        if (obsQ.size() !== 1) begin
            mismatched++;
            $display("[TB] FAIL raw12_count: got %0d beats, want 1", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            compared++;
            if (obsQ[i] !== expQ[i]) begin
                mismatched++;
                $display("[TB] FAIL raw12_beat%0d: got %h, want %h", i, obsQ[i], expQ[i]);
            end
        end
    endtask

    task automatic test_raw8_stream();
        startTest();
        randReady = 1;
        randomPacket(1500);
        modelPacket(0);
        sendPacket(0, 1, 0, 0, 0);
        waitOutputs();
        randReady = 0;
        compared++;
        if (obsQ.size() !== 375) begin
            mismatched++;
            $display("[TB] FAIL raw8_count: got %0d beats, want 375", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            compared++;
            if (obsQ[i] !== expQ[i]) begin
                mismatched++;
                $display("[TB] FAIL raw8_beat%0d: got %h, want %h", i, obsQ[i], expQ[i]);
            end
        end
        compared++;
        if (stallErr !== 0) begin
            mismatched++;
            $display("[TB] FAIL raw8_stall_stable: got %0d changes while stalled, want 0", stallErr);
        end
        compared++;
        if (readyErr !== 0) begin
            mismatched++;
            $display("[TB] FAIL raw8_ready_fill: got %0d cycles ready with fill>12, want 0", readyErr);
        end
        compared++;
        if (errPulses !== 0) begin
            mismatched++;
            $display("[TB] FAIL raw8_len_err: got %0d pulses, want 0", errPulses);
        end
    endtask

    task automatic test_len_err();
        startTest();
        randomPacket(12);
        modelPacket(1);
        sendPacket(1, 1, 0, 0, 0);
        randomPacket(8);
        modelPacket(0);
        sendPacket(0, 1, 0, 0, 0);
        waitOutputs();
        compared++;
        if (obsQ.size() !== 4) begin
            mismatched++;
            $display("[TB] FAIL lenerr_count: got %0d beats, want 4", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            compared++;
            if (obsQ[i] !== expQ[i]) begin
                mismatched++;
                $display("[TB] FAIL lenerr_beat%0d: got %h, want %h", i, obsQ[i], expQ[i]);
            end
        end
        compared++;
        if (errPulses !== 1) begin
            mismatched++;
            $display("[TB] FAIL lenerr_pulses: got %0d, want 1", errPulses);
        end
    endtask

    task automatic test_mode_switch();
        startTest();
        randomPacket(15);
        modelPacket(1);
        sendPacket(1, 1, 1, 2, 0);
        randomPacket(12);
        modelPacket(2);
        sendPacket(2, 1, 0, 0, 0);
        waitOutputs();
        compared++;
        if (obsQ.size() !== expQ.size()) begin
            mismatched++;
            $display("[TB] FAIL switch_count: got %0d beats, want %0d", obsQ.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            compared++;
            if (obsQ[i] !== expQ[i]) begin
                mismatched++;
                $display("[TB] FAIL switch_beat%0d: got %h, want %h", i, obsQ[i], expQ[i]);
            end
        end
        compared++;
        if (errPulses !== expErrPulses) begin
            mismatched++;
            $display("[TB] FAIL switch_len_err: got %0d pulses, want %0d", errPulses, expErrPulses);
        end
    endtask

    task automatic test_reset_midpacket();
        startTest();
        randomPacket(7);
        sendPacket(1, 0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({m_tvalid, m_tuser, m_tlast, len_err, s_tready} !== 5'b0) begin
            mismatched++;
            $display("[TB] FAIL midrst_flags: got valid/user/last/err/ready=%b%b%b%b%b, want 00000",
                     m_tvalid, m_tuser, m_tlast, len_err, s_tready);
        end
        compared++;
        if (m_tdata !== '0) begin
            mismatched++;
            $display("[TB] FAIL midrst_tdata: got %h, want 0", m_tdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if (obsQ.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL midrst_no_output: got %0d beats, want 0", obsQ.size());
        end
        randomPacket(5);
        modelPacket(1);
        sendPacket(1, 1, 0, 0, 0);
        waitOutputs();
        compared++;
        if (obsQ.size() !== 1) begin
            mismatched++;
            $display("[TB] FAIL midrst_count: got %0d beats, want 1", obsQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            compared++;
            if (obsQ[i] !== expQ[i]) begin
                mismatched++;
                $display("[TB] FAIL midrst_beat%0d: got %h, want %h", i, obsQ[i], expQ[i]);
            end
        end
        compared++;
        if (errPulses !== 0) begin
            mismatched++;
            $display("[TB] FAIL midrst_len_err: got %0d pulses, want 0", errPulses);
        end
    endtask

    task automatic test_back_to_back();
        int mode;
        startTest();
        randReady = 1;
        for (int p = 0; p < 10; p++) begin
            mode = int'($urandom_range(0, 3));
            randomPacket((p == 0) ? 0 : (p == 1) ? 3 : int'($urandom_range(1, 40)));
            modelPacket(mode);
            sendPacket(mode, 1, 0, 0, 1'($urandom_range(0, 1)));
        end
        waitOutputs();
        randReady = 0;
        compared++;
        if (obsQ.size() !== expQ.size()) begin
            mismatched++;
            $display("[TB] FAIL b2b_count: got %0d beats, want %0d", obsQ.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            compared++;
            if (obsQ[i] !== expQ[i]) begin
                mismatched++;
                $display("[TB] FAIL b2b_beat%0d: got %h, want %h", i, obsQ[i], expQ[i]);
            end
        end
        compared++;
        if (errPulses !== expErrPulses) begin
            mismatched++;
            $display("[TB] FAIL b2b_len_err: got %0d pulses, want %0d", errPulses, expErrPulses);
        end
        compared++;
        if (stallErr !== 0 || readyErr !== 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_protocol: got stall=%0d ready=%0d violations, want 0/0", stallErr, readyErr);
        end
    endtask

    initial begin
        rst      = 1'b1;
        raw_mode = 2'd0;
        s_tdata  = '0;
        s_tstrb  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] starting csi2_raw_depacker bench");
        test_reset();
        test_raw10_basic();
        test_raw12_basic();
        test_raw8_stream();
        test_len_err();
        test_mode_switch();
        test_reset_midpacket();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
